// File: rtl/rds_group_encoder_pkg.sv
// Shared RDS constants: block offset words, checkword generator and encoder FSM states.
// The subcarrier mixer imports the same package.
package rds_group_encoder_pkg;

   localparam logic [9:0]  c_ofs_a     = 10'h0FC;
   localparam logic [9:0]  c_ofs_b     = 10'h198;
   localparam logic [9:0]  c_ofs_c     = 10'h168;
   localparam logic [9:0]  c_ofs_cp    = 10'h350;
   localparam logic [9:0]  c_ofs_d     = 10'h1B4;
   localparam logic [10:0] c_crc_poly  = 11'h5B9;

   localparam int c_num_blocks = 16;
   localparam int c_num_bytes  = 52;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CRC,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Station settings captured on an accepted start
   typedef struct packed {
      logic [15:0] pi;
      logic [4:0]  pty;
      logic        tp;
      logic        ta;
      logic        ms;
      logic [3:0]  di;
      logic [15:0] af;
      logic [63:0] ps;
   } cfg_t;

endpackage

// File: rtl/rds_group_encoder_if.sv
// Settings/control inputs and RAM write-port outputs of the RDS group encoder.
interface rds_group_encoder_if #(
   parameter int c_addr_bits = 9
);
   logic                   start;
   logic [15:0]            pi;
   logic [4:0]             pty;
   logic                   tp;
   logic                   ta;
   logic                   ms;
   logic [3:0]             di;
   logic [15:0]            af;
   logic [63:0]            ps;
   logic [c_addr_bits-1:0] mem_addr;
   logic [7:0]             mem_data;
   logic                   mem_we;
   logic                   busy;
   logic                   done;

   modport master (
      output start, pi, pty, tp, ta, ms, di, af, ps,
      input  mem_addr, mem_data, mem_we, busy, done
   );

   modport slave (
      input  start, pi, pty, tp, ta, ms, di, af, ps,
      output mem_addr, mem_data, mem_we, busy, done
   );
endinterface

// File: rtl/rds_group_encoder_crc10.sv
// Serial RDS checkword generator: one data bit per enabled cycle, MSB first, zero init.
module rds_crc10
   import rds_group_encoder_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [9:0] o_crc
);

   logic [9:0] r_crc;
   logic       w_fb;

   assign w_fb  = r_crc[9] ^ i_bit;
   assign o_crc = r_crc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_crc <= '0;
      end else if (i_clr) begin
         r_crc <= '0;
      end else if (i_en) begin
         r_crc <= {r_crc[8:0], 1'b0} ^ (w_fb ? c_crc_poly[9:0] : 10'h000);
      end
   end

endmodule

// File: rtl/rds_group_encoder.sv
// Encodes four type-0A PS groups from latched station settings and streams the
// 416 checkword-protected bits, MSB first, into the message RAM as 52 bytes.
module rds_group_encoder
   import rds_group_encoder_pkg::*;
#(
   parameter int c_base_addr = 0,
   parameter int c_addr_bits = 9
)(
   input  logic             clk,
   input  logic             reset,
   rds_group_encoder_if.slave bus
);

   localparam logic [c_addr_bits-1:0] lp_base = c_addr_bits'(c_base_addr);

   state_t                 r_state;
   state_t                 w_state_next;
   cfg_t                   r_cfg;
   logic [3:0]             r_blk;
   logic [4:0]             r_bit_cnt;
   logic [15:0]            r_word;
   logic [9:0]             r_ofs;
   logic [6:0]             r_acc;
   logic [2:0]             r_acc_cnt;
   logic [5:0]             r_byte_cnt;
   logic [c_addr_bits-1:0] r_mem_addr;
   logic [7:0]             r_mem_data;
   logic                   r_mem_we;
   logic                   r_done;

   logic                   w_accept;
   logic                   w_crc_clr;
   logic                   w_crc_en;
   logic                   w_shift;
   logic                   w_crc_bit;
   logic                   w_tx_bit;
   logic [9:0]             w_crc;
   logic [25:0]            w_block;
   logic [1:0]             w_seg;
   logic [15:0]            w_blk_word;
   logic [9:0]             w_blk_ofs;

   rds_crc10 u_crc (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_crc_clr),
      .i_en  (w_crc_en),
      .i_bit (w_crc_bit),
      .o_crc (w_crc)
   );

   // Block selection: r_blk[3:2] is the segment/group, r_blk[1:0] picks A/B/C/D
   assign w_seg = r_blk[3:2];

   always_comb begin
      w_blk_word = r_cfg.pi;
      w_blk_ofs  = c_ofs_a;
      case (r_blk[1:0])
         2'd0: begin
            w_blk_word = r_cfg.pi;
            w_blk_ofs  = c_ofs_a;
         end
         2'd1: begin
            w_blk_word = {4'b0000, 1'b0, r_cfg.tp, r_cfg.pty, r_cfg.ta, r_cfg.ms,
                          r_cfg.di[2'd3 - w_seg], w_seg};
            w_blk_ofs  = c_ofs_b;
         end
         2'd2: begin
            w_blk_word = r_cfg.af;
            w_blk_ofs  = c_ofs_c;
         end
         default: begin
            w_blk_word = r_cfg.ps[6'd63 - {w_seg, 4'b0000} -: 16];
            w_blk_ofs  = c_ofs_d;
         end
      endcase
   end

   assign w_crc_bit = r_word[4'd15 - r_bit_cnt[3:0]];
   assign w_block   = {r_word, w_crc ^ r_ofs};
   assign w_tx_bit  = w_block[5'd25 - r_bit_cnt];

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_crc_clr    = 1'b0;
      w_crc_en     = 1'b0;
      w_shift      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A start coinciding with the done pulse is not a new request
            if (bus.start && !r_done) begin
               w_accept     = 1'b1;
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_crc_clr    = 1'b1;
            w_state_next = ST_CRC;
         end
         ST_CRC: begin
            w_crc_en = 1'b1;
            if (r_bit_cnt == 5'd15) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_bit_cnt == 5'd25) begin
               w_state_next = (r_blk == 4'd15) ? ST_DONE : ST_LOAD;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cfg      <= '0;
         r_blk      <= '0;
         r_bit_cnt  <= '0;
         r_word     <= '0;
         r_ofs      <= '0;
         r_acc      <= '0;
         r_acc_cnt  <= '0;
         r_byte_cnt <= '0;
         r_mem_addr <= lp_base;
         r_mem_data <= '0;
         r_mem_we   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= (r_state == ST_DONE);
         if (w_accept) begin
            r_cfg      <= {bus.pi, bus.pty, bus.tp, bus.ta, bus.ms, bus.di, bus.af, bus.ps};
            r_blk      <= '0;
            r_byte_cnt <= '0;
            r_acc_cnt  <= '0;
         end
         if (r_state == ST_LOAD) begin
            r_word    <= w_blk_word;
            r_ofs     <= w_blk_ofs;
            r_bit_cnt <= '0;
         end
         if (w_crc_en) begin
            r_bit_cnt <= (r_bit_cnt == 5'd15) ? 5'd0 : r_bit_cnt + 5'd1;
         end
         // The accumulator runs across block boundaries; a byte completes every 8 bits
         if (w_shift) begin
            r_acc     <= {r_acc[5:0], w_tx_bit};
            r_acc_cnt <= r_acc_cnt + 3'd1;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_acc_cnt == 3'd7) begin
               r_mem_we   <= 1'b1;
               r_mem_data <= {r_acc, w_tx_bit};
               r_mem_addr <= lp_base + c_addr_bits'(r_byte_cnt);
               r_byte_cnt <= r_byte_cnt + 6'd1;
            end
            if (r_bit_cnt == 5'd25) begin
               r_blk <= r_blk + 4'd1;
            end
         end
      end
   end

   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_data = r_mem_data;
   assign bus.mem_we   = r_mem_we;
   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.done     = r_done;

endmodule

// File: tb/tb_rds_group_encoder.sv
// Directed/randomised bench for rds_group_encoder: two instances (base 0 and base 500)
// checked byte-for-byte against a polynomial-division reference of the RDS groups.
module tb_rds_group_encoder;

   logic clk = 1'b0;
   logic reset;

   always #20 clk = ~clk;

   logic        t_start = 1'b0;
   logic [15:0] t_pi    = '0;
   logic [4:0]  t_pty   = '0;
   logic        t_tp    = 1'b0;
   logic        t_ta    = 1'b0;
   logic        t_ms    = 1'b0;
   logic [3:0]  t_di    = '0;
   logic [15:0] t_af    = '0;
   logic [63:0] t_ps    = '0;

   rds_group_encoder_if #(.c_addr_bits(9)) u_if0 ();
   rds_group_encoder_if #(.c_addr_bits(9)) u_if1 ();

   assign u_if0.start = t_start;  assign u_if1.start = t_start;
   assign u_if0.pi    = t_pi;     assign u_if1.pi    = t_pi;
   assign u_if0.pty   = t_pty;    assign u_if1.pty   = t_pty;
   assign u_if0.tp    = t_tp;     assign u_if1.tp    = t_tp;
   assign u_if0.ta    = t_ta;     assign u_if1.ta    = t_ta;
   assign u_if0.ms    = t_ms;     assign u_if1.ms    = t_ms;
   assign u_if0.di    = t_di;     assign u_if1.di    = t_di;
   assign u_if0.af    = t_af;     assign u_if1.af    = t_af;
   assign u_if0.ps    = t_ps;     assign u_if1.ps    = t_ps;

   rds_group_encoder #(.c_base_addr(0), .c_addr_bits(9)) u_dut0 (
      .clk (clk), .reset (reset), .bus (u_if0)
   );
   rds_group_encoder #(.c_base_addr(500), .c_addr_bits(9)) u_dut1 (
      .clk (clk), .reset (reset), .bus (u_if1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] wr_data0 [$];
   logic [8:0] wr_addr0 [$];
   logic [7:0] wr_data1 [$];
   logic [8:0] wr_addr1 [$];
   int         done_cnt0 = 0;
   int         done_cnt1 = 0;
   logic       busy_at_done0 = 1'b1;
   logic       busy_at_done1 = 1'b1;
   logic [7:0] exp_b [52];

   always @(negedge clk) begin
      if (u_if0.mem_we === 1'b1) begin
         wr_data0.push_back(u_if0.mem_data);
         wr_addr0.push_back(u_if0.mem_addr);
      end
      if (u_if1.mem_we === 1'b1) begin
         wr_data1.push_back(u_if1.mem_data);
         wr_addr1.push_back(u_if1.mem_addr);
      end
      if (u_if0.done === 1'b1) begin
         done_cnt0++;
         busy_at_done0 = u_if0.busy;
      end
      if (u_if1.done === 1'b1) begin
         done_cnt1++;
         busy_at_done1 = u_if1.busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Checkword by long division of data*x^10 by the generator, then offset XOR
   function automatic logic [9:0] ref_check(input logic [15:0] d, input logic [9:0] ofs);
      logic [25:0] r;
      logic [25:0] g;
      r = {d, 10'b0};
      g = 26'h5B9;
      for (int i = 25; i >= 10; i--) begin
         if (r[i]) r = r ^ (g << (i - 10));
      end
      return r[9:0] ^ ofs;
   endfunction

   task automatic build_ref();
      bit          stream [$];
      logic [15:0] w;
      logic [9:0]  ofs;
      logic [25:0] blk;
      logic [1:0]  s2;
      logic [7:0]  c0;
      logic [7:0]  c1;
      for (int s = 0; s < 4; s++) begin
         s2 = s[1:0];
         for (int b = 0; b < 4; b++) begin
            case (b)
               0: begin w = t_pi; ofs = 10'h0FC; end
               1: begin w = {4'b0000, 1'b0, t_tp, t_pty, t_ta, t_ms, t_di[3 - s], s2}; ofs = 10'h198; end
               2: begin w = t_af; ofs = 10'h168; end
               default: begin
                  c0 = t_ps[63 - 16 * s -: 8];
                  c1 = t_ps[55 - 16 * s -: 8];
                  w = {c0, c1};
                  ofs = 10'h1B4;
               end
            endcase
            blk = {w, ref_check(w, ofs)};
            for (int k = 25; k >= 0; k--) stream.push_back(blk[k]);
         end
      end
      for (int n = 0; n < 52; n++) begin
         exp_b[n] = '0;
         for (int k = 0; k < 8; k++) exp_b[n] = {exp_b[n][6:0], stream[8 * n + k]};
      end
   endtask

   task automatic clear_mon();
      wr_data0.delete(); wr_addr0.delete();
      wr_data1.delete(); wr_addr1.delete();
      done_cnt0 = 0; done_cnt1 = 0;
      busy_at_done0 = 1'b1; busy_at_done1 = 1'b1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 t_start = 1'b1;
      @(posedge clk); #1 t_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int tail);
      int cyc;
      cyc = 0;
      while ((done_cnt0 == 0 || done_cnt1 == 0) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " done_seen"}, 32'(done_cnt0 > 0 && done_cnt1 > 0), 32'd1);
      repeat (tail) @(negedge clk);
   endtask

   task automatic verify_run(input string tag);
      check({tag, " nwr0"}, 32'(wr_data0.size()), 32'd52);
      check({tag, " nwr1"}, 32'(wr_data1.size()), 32'd52);
      check({tag, " done0"}, 32'(done_cnt0), 32'd1);
      check({tag, " done1"}, 32'(done_cnt1), 32'd1);
      check({tag, " busy_at_done0"}, 32'(busy_at_done0), 32'd0);
      check({tag, " busy_at_done1"}, 32'(busy_at_done1), 32'd0);
      for (int i = 0; i < 52; i++) begin
         if (i < wr_data0.size()) begin
            check($sformatf("%s d0[%0d]", tag, i), 32'(wr_data0[i]), 32'(exp_b[i]));
            check($sformatf("%s a0[%0d]", tag, i), 32'(wr_addr0[i]), 32'(i));
         end
         if (i < wr_data1.size()) begin
            check($sformatf("%s d1[%0d]", tag, i), 32'(wr_data1[i]), 32'(exp_b[i]));
            check($sformatf("%s a1[%0d]", tag, i), 32'(wr_addr1[i]), 32'((500 + i) % 512));
         end
      end
      $display("run %s: writes %0d/%0d done %0d/%0d", tag, wr_data0.size(), wr_data1.size(),
               done_cnt0, done_cnt1);
   endtask

   task automatic randomize_cfg();
      t_pi  = 16'($urandom);
      t_pty = 5'($urandom);
      t_tp  = 1'($urandom);
      t_ta  = 1'($urandom);
      t_ms  = 1'($urandom);
      t_di  = 4'($urandom);
      t_af  = 16'($urandom);
      t_ps  = {$urandom, $urandom};
   endtask

   initial begin
      int  cyc;
      int  p;
      int  saved;
      logic [7:0] byte_v;
      logic       di_bit;
      logic [1:0] seg_bits;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst addr0", 32'(u_if0.mem_addr), 32'd0);
      check("rst addr1", 32'(u_if1.mem_addr), 32'd500);
      check("rst data0", 32'(u_if0.mem_data), 32'd0);
      check("rst we0",   32'(u_if0.mem_we),   32'd0);
      check("rst busy0", 32'(u_if0.busy),     32'd0);
      check("rst done0", 32'(u_if0.done),     32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: all-zero settings
      clear_mon();
      build_ref();
      pulse_start();
      check("s1 busy_after_start", 32'(u_if0.busy), 32'd1);
      wait_done("s1", 10);
      check("s1 byte0", 32'(wr_data0.size() > 0 ? wr_data0[0] : 8'hxx), 32'h00);
      check("s1 byte1", 32'(wr_data0.size() > 1 ? wr_data0[1] : 8'hxx), 32'h00);
      check("s1 byte2", 32'(wr_data0.size() > 2 ? wr_data0[2] : 8'hxx), 32'h3F);
      verify_run("s1");

      // 2: realistic station, other fields random
      randomize_cfg();
      t_pi = 16'hC201;
      t_ps = "TEST FM ";
      clear_mon();
      build_ref();
      pulse_start();
      wait_done("s2", 10);
      verify_run("s2");

      // 3: DI bit placement and segment address field
      randomize_cfg();
      t_di = 4'b1000;
      clear_mon();
      build_ref();
      pulse_start();
      wait_done("s3", 10);
      verify_run("s3");
      for (int s = 0; s < 4; s++) begin
         p = 26 * (4 * s + 1) + 13;
         di_bit = 1'bx;
         seg_bits = 2'bxx;
         if (wr_data0.size() == 52) begin
            byte_v = wr_data0[p / 8];
            di_bit = byte_v[7 - (p % 8)];
            byte_v = wr_data0[(p + 1) / 8];
            seg_bits[1] = byte_v[7 - ((p + 1) % 8)];
            byte_v = wr_data0[(p + 2) / 8];
            seg_bits[0] = byte_v[7 - ((p + 2) % 8)];
         end
         check($sformatf("s3 di g%0d", s), 32'(di_bit), 32'(s == 0));
         check($sformatf("s3 seg g%0d", s), 32'(seg_bits), 32'(s));
      end

      // 4: start and input changes while busy are ignored
      randomize_cfg();
      clear_mon();
      build_ref();
      pulse_start();
      repeat (100) @(posedge clk);
      #1;
      randomize_cfg();
      pulse_start();
      wait_done("s4", 800);
      verify_run("s4");

      // 5: reset mid-encode after 20 bytes
      randomize_cfg();
      clear_mon();
      build_ref();
      pulse_start();
      cyc = 0;
      while (wr_data0.size() < 20 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("s5 reached20", 32'(wr_data0.size()), 32'd20);
      #1 reset = 1'b1;
      #1;
      check("s5 we0_async",   32'(u_if0.mem_we), 32'd0);
      check("s5 busy0_async", 32'(u_if0.busy),   32'd0);
      check("s5 we1_async",   32'(u_if1.mem_we), 32'd0);
      check("s5 busy1_async", 32'(u_if1.busy),   32'd0);
      saved = wr_data0.size();
      for (int i = 0; i < 20; i++) begin
         if (i < wr_data0.size())
            check($sformatf("s5 partial[%0d]", i), 32'(wr_data0[i]), 32'(exp_b[i]));
      end
      repeat (4) @(negedge clk);
      check("s5 nowrites", 32'(wr_data0.size()), 32'(saved));
      check("s5 addr0", 32'(u_if0.mem_addr), 32'd0);
      check("s5 addr1", 32'(u_if1.mem_addr), 32'd500);
      check("s5 done0", 32'(u_if0.done), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      randomize_cfg();
      clear_mon();
      build_ref();
      pulse_start();
      wait_done("s5r", 10);
      verify_run("s5r");

      // Extra randomised runs
      for (int r = 0; r < 3; r++) begin
         randomize_cfg();
         clear_mon();
         build_ref();
         pulse_start();
         wait_done($sformatf("rnd%0d", r), 10);
         verify_run($sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
